// File: rtl/pb_monitor.sv
// pb_monitor: NCH independent masked signal checkers (VAL/WAIT/KEEP/BELOW/ABOVE) with cycle timeouts.
// Optional feature macro PB_DEBOUNCE_EN: run-based decisions need DEB consecutive samples.
module pb_monitor #(
    parameter int W   = 16,
    parameter int NCH = 4,
    parameter int TW  = 24,
    parameter int DEB = 2,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] sig,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [CW-1:0]    cmd_ch,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_exp,
    input  logic [W-1:0]     cmd_msk,
    input  logic [TW-1:0]    cmd_tmo,
    output logic [NCH-1:0]   ch_busy,
    output logic [NCH-1:0]   ch_done,
    output logic [NCH-1:0]   ch_pass,
    output logic             err,
    output logic [CW-1:0]    err_ch
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [2:0] OP_VAL   = 3'd0;
    localparam logic [2:0] OP_WAIT  = 3'd1;
    localparam logic [2:0] OP_KEEP  = 3'd2;
    localparam logic [2:0] OP_BELOW = 3'd3;
    localparam logic [2:0] OP_ABOVE = 3'd4;
    localparam logic [2:0] OP_ABORT = 3'd7;

`ifdef PB_DEBOUNCE_EN
    localparam int DB = DEB;
`else
    // Without debounce every run-based decision is a single-sample decision.
    localparam int DB = (DEB >= 1) ? 1 : 1;
`endif
    localparam int RW = $clog2(DB + 1);
    localparam logic [RW:0] DB_C  = (RW+1)'(DB);
    localparam logic [RW:0] ONE_R = (RW+1)'(1);
    localparam logic [CW:0] NCH_C = (CW+1)'(NCH);

    // Care-bit equality; X/Z on a care bit yields a mismatch.
    function automatic logic f_match(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] m);
        return (((s ^ e) & m) === {W{1'b0}});
    endfunction

    function automatic logic f_below(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] m);
        logic [W-1:0] sm;
        sm = s & m;
        return !$isunknown(sm) && (sm <= e);
    endfunction

    function automatic logic f_above(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] m);
        logic [W-1:0] sm;
        sm = s & m;
        return !$isunknown(sm) && (sm >= e);
    endfunction

    logic           ch_ok_s;
    logic           is_abort_s;
    logic [NCH-1:0] busy_s;
    logic [NCH-1:0] fail_s;
    logic [CW-1:0]  first_s;
    logic           err_r;
    logic [CW-1:0]  err_ch_r;

    assign ch_ok_s    = ({1'b0, cmd_ch} < NCH_C);
    assign is_abort_s = (cmd_op == OP_ABORT);

    // Ready: aborts and out-of-range channels always; otherwise only when the channel is idle.
    always_comb begin
        cmd_rdy = 1'b1;
        if (!is_abort_s && ch_ok_s) begin
            cmd_rdy = !busy_s[cmd_ch];
        end else begin
            cmd_rdy = 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t        state_r;
        logic [2:0]    op_r;
        logic [W-1:0]  exp_r;
        logic [W-1:0]  msk_r;
        logic [TW-1:0] cnt_r;
        logic [RW-1:0] run_r;
        logic [RW-1:0] run_nx_s;
        logic [RW:0]   run_inc_s;
        logic [W-1:0]  s_s;
        logic          sel_s, acc_s, abort_s, match_s, cond_s, dec_s, pas_s;
        logic          done_r, pass_r;

        assign s_s       = sig[c*W +: W];
        assign sel_s     = cmd_vld && ch_ok_s && (cmd_ch == CW'(c));
        assign acc_s     = sel_s && !is_abort_s && (state_r == ST_IDLE);
        assign abort_s   = sel_s && is_abort_s;
        assign match_s   = f_match(s_s, exp_r, msk_r);
        assign run_inc_s = {1'b0, run_r} + ONE_R;

        // Condition watched by the run-until-true ops.
        always_comb begin
            case (op_r)
                OP_WAIT:  cond_s = match_s;
                OP_BELOW: cond_s = f_below(s_s, exp_r, msk_r);
                OP_ABOVE: cond_s = f_above(s_s, exp_r, msk_r);
                default:  cond_s = match_s;
            endcase
        end

        // Per-sample decision; cnt_r == 0 marks the last allowed sample.
        always_comb begin
            dec_s    = 1'b0;
            pas_s    = 1'b0;
            run_nx_s = '0;
            case (op_r)
                OP_VAL: begin
                    dec_s = 1'b1;
                    pas_s = match_s;
                end
                OP_WAIT, OP_BELOW, OP_ABOVE: begin
                    if (cond_s && (run_inc_s >= DB_C)) begin
                        dec_s = 1'b1;
                        pas_s = 1'b1;
                    end else if (cnt_r == {TW{1'b0}}) begin
                        dec_s = 1'b1;
                        pas_s = 1'b0;
                    end else begin
                        run_nx_s = cond_s ? run_inc_s[RW-1:0] : {RW{1'b0}};
                    end
                end
                OP_KEEP: begin
                    if (!match_s && (run_inc_s >= DB_C)) begin
                        dec_s = 1'b1;
                        pas_s = 1'b0;
                    end else if (cnt_r == {TW{1'b0}}) begin
                        dec_s = 1'b1;
                        pas_s = 1'b1;
                    end else begin
                        run_nx_s = match_s ? {RW{1'b0}} : run_inc_s[RW-1:0];
                    end
                end
                default: begin
                    dec_s = 1'b1;
                    pas_s = 1'b0;
                end
            endcase
        end

        // Channel FSM: latch the command on accept, sample every cycle while running.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_IDLE;
                op_r    <= OP_VAL;
                exp_r   <= '0;
                msk_r   <= '0;
                cnt_r   <= '0;
                run_r   <= '0;
                done_r  <= 1'b0;
                pass_r  <= 1'b0;
            end else begin
                done_r <= 1'b0;
                pass_r <= 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        if (acc_s) begin
                            state_r <= ST_RUN;
                            op_r    <= cmd_op;
                            exp_r   <= cmd_exp;
                            msk_r   <= cmd_msk;
                            cnt_r   <= cmd_tmo;
                            run_r   <= '0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (abort_s) begin
                            state_r <= ST_IDLE;
                        end else if (dec_s) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                            pass_r  <= pas_s;
                        end else begin
                            cnt_r <= cnt_r - TW'(1);
                            run_r <= run_nx_s;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end

        assign busy_s[c]  = (state_r == ST_RUN);
        assign fail_s[c]  = (state_r == ST_RUN) && !abort_s && dec_s && !pas_s;
        assign ch_busy[c] = busy_s[c];
        assign ch_done[c] = done_r;
        assign ch_pass[c] = pass_r;
    end

    // Lowest failing channel index wins on simultaneous failures.
    always_comb begin
        first_s = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            first_s = fail_s[c] ? CW'(c) : first_s;
        end
    end

    // Sticky error; err_ch only captures the first failure after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r    <= 1'b0;
            err_ch_r <= '0;
        end else if (!err_r && (|fail_s)) begin
            err_r    <= 1'b1;
            err_ch_r <= first_s;
        end else begin
            err_r    <= err_r;
            err_ch_r <= err_ch_r;
        end
    end

    assign err    = err_r;
    assign err_ch = err_ch_r;

endmodule
